// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, control-bundle layout
// and the load-use stall state encoding.
package id_stage_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int ALU_OP_W = 4;
  localparam int BRU_OP_W = 3;
  localparam int LS_OP_W  = 3;
  localparam int CTRL_W   = 6 + ALU_OP_W + BRU_OP_W + LS_OP_W;

  // {RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, ALU_op, BRU_op, LS_op}
  localparam int CTRL_LS       = 0;
  localparam int CTRL_BRU      = CTRL_LS + LS_OP_W;
  localparam int CTRL_ALU      = CTRL_BRU + BRU_OP_W;
  localparam int CTRL_BRANCH   = CTRL_ALU + ALU_OP_W;
  localparam int CTRL_MEMWRITE = CTRL_BRANCH + 1;
  localparam int CTRL_MEMREAD  = CTRL_MEMWRITE + 1;
  localparam int CTRL_MEMTOREG = CTRL_MEMREAD + 1;
  localparam int CTRL_ALUSRC   = CTRL_MEMTOREG + 1;
  localparam int CTRL_REGWRITE = CTRL_ALUSRC + 1;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'b1111;
  localparam logic [BRU_OP_W-1:0] BRU_JAL  = 3'b010;
  localparam logic [BRU_OP_W-1:0] BRU_JALR = 3'b011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard detection: qualifies source registers by opcode usage and
// compares them against the in-flight load rd and the pending stall rd.
module id_hazard_unit
  import id_stage_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              inst_valid,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] pend_rd,
  output logic              hazard_now,
  output logic              uses_pend
);

  logic use1, use2;

  assign use1 = uses_rs1(opcode);
  assign use2 = uses_rs2(opcode);

  // x0 is hardwired, so a write to it can never create a dependency
  function automatic logic reads_reg(input logic [REG_AW-1:0] r);
    return (r != '0) && ((use1 && rs1 == r) || (use2 && rs2 == r));
  endfunction

  assign hazard_now = inst_valid && ex_valid && ex_mem_read && reads_reg(ex_rd);
  assign uses_pend  = inst_valid && reads_reg(pend_rd);

endmodule

// File: rtl/id_stage_pipe_controller.sv
// Main decoder: maps opcode/funct fields onto the packed control bundle.
module id_stage_pipe_controller
  import id_stage_pipe_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALU +: ALU_OP_W]      = {funct7_5, funct3};
      end
      OP_IMM: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALUSRC]               = 1'b1;
        // only the shift-right immediate carries an op modifier in funct7
        ctrl[CTRL_ALU +: ALU_OP_W]      = {(funct3 == 3'b101) & funct7_5, funct3};
      end
      OP_LOAD: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALUSRC]               = 1'b1;
        ctrl[CTRL_MEMTOREG]             = 1'b1;
        ctrl[CTRL_MEMREAD]              = 1'b1;
        ctrl[CTRL_ALU +: ALU_OP_W]      = ALU_ADD;
        ctrl[CTRL_LS +: LS_OP_W]        = funct3;
      end
      OP_STORE: begin
        ctrl[CTRL_ALUSRC]               = 1'b1;
        ctrl[CTRL_MEMWRITE]             = 1'b1;
        ctrl[CTRL_ALU +: ALU_OP_W]      = ALU_ADD;
        ctrl[CTRL_LS +: LS_OP_W]        = funct3;
      end
      OP_BRANCH: begin
        ctrl[CTRL_BRANCH]               = 1'b1;
        ctrl[CTRL_BRU +: BRU_OP_W]      = funct3;
      end
      OP_LUI: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALUSRC]               = 1'b1;
        ctrl[CTRL_ALU +: ALU_OP_W]      = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALUSRC]               = 1'b1;
        ctrl[CTRL_ALU +: ALU_OP_W]      = ALU_ADD;
      end
      OP_JAL: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_BRANCH]               = 1'b1;
        ctrl[CTRL_BRU +: BRU_OP_W]      = BRU_JAL;
      end
      OP_JALR: begin
        ctrl[CTRL_REGWRITE]             = 1'b1;
        ctrl[CTRL_ALUSRC]               = 1'b1;
        ctrl[CTRL_BRANCH]               = 1'b1;
        ctrl[CTRL_BRU +: BRU_OP_W]      = BRU_JALR;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes the IF/ID instruction, owns the ID/EX register and
// inserts load-use bubbles with a configurable depth; honours flush and EX backpressure.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

  function automatic logic signed [XLEN-1:0] sext_imm(input logic [31:0] inst);
    logic signed [31:0] imm32;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {inst[31:12], 12'h000};
      OP_JAL:                   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  // Stage p0: combinational decode of the IF/ID instruction
  logic [CTRL_W-1:0]        ctrl_p0;
  logic signed [XLEN-1:0]   imm_p0;
  logic [REG_AW-1:0]        rs1_p0, rs2_p0, rd_p0;

  // Stage p1: ID/EX register
  logic                     vld_p1;
  logic [XLEN-1:0]          pc_p1;
  logic [REG_AW-1:0]        rs1_p1, rs2_p1, rd_p1;
  logic signed [XLEN-1:0]   imm_p1;
  logic [CTRL_W-1:0]        ctrl_p1;

  state_t                   state;
  logic [1:0]               cnt;
  logic [REG_AW-1:0]        pend_rd;
  logic                     hazard_now, uses_pend, stall_bubble;

  assign rs1_p0 = REG_AW'(if_inst[19:15]);
  assign rs2_p0 = REG_AW'(if_inst[24:20]);
  assign rd_p0  = REG_AW'(if_inst[11:7]);
  assign imm_p0 = sext_imm(if_inst);

  id_stage_pipe_controller u_ctrl (
    .opcode   (if_inst[6:0]),
    .funct3   (if_inst[14:12]),
    .funct7_5 (if_inst[30]),
    .ctrl     (ctrl_p0)
  );

  id_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .opcode      (if_inst[6:0]),
    .rs1         (rs1_p0),
    .rs2         (rs2_p0),
    .inst_valid  (if_valid),
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1[CTRL_MEMREAD]),
    .ex_rd       (rd_p1),
    .pend_rd     (pend_rd),
    .hazard_now  (hazard_now),
    .uses_pend   (uses_pend)
  );

  assign stall_bubble = (state == ST_RUN && hazard_now) || (state == ST_STALL && uses_pend);
  // flush always drops the ID instruction, even while EX is stalled
  assign id_ready     = flush || (ex_ready && !stall_bubble);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
      imm_p1  <= '0;
      ctrl_p1 <= '0;
      state   <= ST_RUN;
      cnt     <= 2'd0;
      pend_rd <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      state  <= ST_RUN;
      cnt    <= 2'd0;
    end else if (!ex_ready) begin
      vld_p1 <= vld_p1;
    end else if (state == ST_RUN && hazard_now) begin
      vld_p1  <= 1'b0;
      pend_rd <= rd_p1;
      if (LOAD_USE_STALL > 1) begin
        state <= ST_STALL;
        cnt   <= STALL_INIT;
      end
    end else if (state == ST_STALL && uses_pend) begin
      vld_p1 <= 1'b0;
      cnt    <= cnt - 2'd1;
      if (cnt == 2'd1) state <= ST_RUN;
    end else begin
      vld_p1  <= if_valid;
      pc_p1   <= if_pc;
      rs1_p1  <= rs1_p0;
      rs2_p1  <= rs2_p0;
      rd_p1   <= rd_p0;
      imm_p1  <= imm_p0;
      ctrl_p1 <= ctrl_p0;
      state   <= ST_RUN;
      cnt     <= 2'd0;
    end
  end

  // Stage p1 outputs toward EX and register-file read addresses
  assign ex_valid = vld_p1;
  assign ex_pc    = pc_p1;
  assign ex_rs1   = rs1_p1;
  assign ex_rs2   = rs2_p1;
  assign ex_rd    = rd_p1;
  assign ex_imm   = imm_p1;
  assign ex_ctrl  = ctrl_p1;
  assign rs1_addr = rs1_p0;
  assign rs2_addr = rs2_p0;

endmodule
